// File: rtl/hvac_pkg.sv
// Shared types and defaults for the HVAC sequencer: FSM state encoding, light modes, parameter defaults.
package hvac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEAT    = 3'd1,
        ST_COOL    = 3'd2,
        ST_LOCKOUT = 3'd3,
        ST_FAULT   = 3'd4
    } state_e;

    // Light modes packed as {LR, LG}.
    localparam logic [1:0] LIGHT_OFF   = 2'b00;
    localparam logic [1:0] LIGHT_RED   = 2'b10;
    localparam logic [1:0] LIGHT_GREEN = 2'b01;

    localparam int DEF_TEMP_W  = 12;
    localparam int DEF_HYST    = 20;
    localparam int DEF_MIN_ON  = 8;
    localparam int DEF_MIN_OFF = 4;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_MAX_RUN = 200;

endpackage

// File: rtl/hvac_temp_cmp.sv
// Widened signed subtract-and-compare: start requests (with hysteresis) and run-complete flags.
module hvac_temp_cmp
    import hvac_pkg::*;
#(
    parameter int TEMP_W = DEF_TEMP_W,
    parameter int HYST   = DEF_HYST
) (
    input  logic signed [TEMP_W-1:0] target,
    input  logic signed [TEMP_W-1:0] ambient,
    output logic                     need_heat,
    output logic                     need_cool,
    output logic                     heat_done,
    output logic                     cool_done
);

    // One extra bit keeps target-ambient exact across the full signed range.
    typedef logic signed [TEMP_W:0] wide_t;
    localparam wide_t HYST_W = wide_t'(HYST);

    wide_t up;
    wide_t dn;

    always_comb begin
        up        = wide_t'(target) - wide_t'(ambient);
        dn        = wide_t'(ambient) - wide_t'(target);
        need_heat = (up >= HYST_W);
        need_cool = (dn >= HYST_W);
        heat_done = (ambient >= target);
        cool_done = (ambient <= target);
    end

endmodule

// File: rtl/hvac_sequencer.sv
// HVAC plant sequencer: tick-driven heat/cool FSM with hysteresis, min-run and lockout, registered outputs.
// Optional watchdog FAULT state enabled by defining HVAC_WATCHDOG_EN.
module hvac_sequencer
    import hvac_pkg::*;
#(
    parameter int TEMP_W  = DEF_TEMP_W,
    parameter int HYST    = DEF_HYST,
    parameter int MIN_ON  = DEF_MIN_ON,
    parameter int MIN_OFF = DEF_MIN_OFF,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MAX_RUN = DEF_MAX_RUN
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     enable,
    input  logic signed [TEMP_W-1:0] target,
    input  logic signed [TEMP_W-1:0] ambient,
    output logic                     heat_on,
    output logic                     cool_on,
    output logic                     LR,
    output logic                     LG,
    output logic [2:0]               state,
    output logic                     fault
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] run_q, run_d, run_inc;
    logic [CNT_W-1:0] lock_q, lock_d, lock_inc;
    logic             need_heat, need_cool, heat_done, cool_done;
    logic             run_done, lock_done;
    logic             heat_d, cool_d, fault_d;
    logic [1:0]       lights_d;

    hvac_temp_cmp #(
        .TEMP_W (TEMP_W),
        .HYST   (HYST)
    ) u_cmp (
        .target    (target),
        .ambient   (ambient),
        .need_heat (need_heat),
        .need_cool (need_cool),
        .heat_done (heat_done),
        .cool_done (cool_done)
    );

    assign run_inc   = (&run_q)  ? run_q  : run_q + 1'b1;
    assign lock_inc  = (&lock_q) ? lock_q : lock_q + 1'b1;
    assign run_done  = (int'(run_q) >= MIN_ON);
    // MIN_OFF=0 still costs one lockout tick.
    assign lock_done = (int'(lock_q) + 1 >= MIN_OFF);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state_q;
        run_d   = run_q;
        lock_d  = lock_q;
        case (state_q)
            ST_IDLE: begin
                if (tick && enable) begin
                    if (need_heat) begin
                        state_d = ST_HEAT;
                        run_d   = '0;
                    end else if (need_cool) begin
                        state_d = ST_COOL;
                        run_d   = '0;
                    end
                end
            end
            ST_HEAT, ST_COOL: begin
                if (!enable) begin
                    state_d = ST_LOCKOUT;
                    lock_d  = '0;
                end else if (tick) begin
                    if (run_done && ((state_q == ST_HEAT) ? heat_done : cool_done)) begin
                        state_d = ST_LOCKOUT;
                        lock_d  = '0;
                    end
`ifdef HVAC_WATCHDOG_EN
                    else if (int'(run_inc) >= MAX_RUN) begin
                        state_d = ST_FAULT;
                        run_d   = run_inc;
                    end
`endif
                    else begin
                        run_d = run_inc;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (tick) begin
                    lock_d = lock_inc;
                    if (lock_done) state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
`ifdef HVAC_WATCHDOG_EN
                if (!enable) begin
                    state_d = ST_LOCKOUT;
                    lock_d  = '0;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        heat_d = (state_d == ST_HEAT);
        cool_d = (state_d == ST_COOL);
`ifdef HVAC_WATCHDOG_EN
        fault_d = (state_d == ST_FAULT);
`else
        fault_d = 1'b0;
`endif
        if (heat_d || cool_d || fault_d)         lights_d = LIGHT_RED;
        else if (state_d == ST_IDLE && enable)   lights_d = LIGHT_GREEN;
        else                                     lights_d = LIGHT_OFF;
    end

    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= ST_IDLE;
            run_q   <= '0;
            lock_q  <= '0;
            heat_on <= 1'b0;
            cool_on <= 1'b0;
            fault   <= 1'b0;
            LR      <= 1'b0;
            LG      <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            lock_q  <= lock_d;
            heat_on <= heat_d;
            cool_on <= cool_d;
            fault   <= fault_d;
            {LR, LG} <= lights_d;
        end
    end

    assign state = state_q;

endmodule
